// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, queue entry and arbitration types for the register file write-back path
package rf_pkg;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREG = 8;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
  typedef enum logic {RR_ALU, RR_MEM} rr_t;
  function automatic rr_t rr_flip(input rr_t r);
    return (r == RR_ALU) ? RR_MEM : RR_ALU;
  endfunction
endpackage

// File: rtl/rf_wb_queue_wb_fifo.sv
// wb_fifo: circular write-back buffer, two ordered writes and one read per cycle, entries exposed for forwarding
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr0_en,
  input  wb_entry_t                    wr0,
  input  logic                         wr1_en,
  input  wb_entry_t                    wr1,
  input  logic                         rd_en,
  output wb_entry_t [DEPTH-1:0]        ents,
  output logic [DEPTH-1:0]             vld,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wr1_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  assign wr1_idx = wr_q + PW'(1);
  // wr1 is only ever used together with wr0, so it always lands one slot behind it
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    rd_d  = rd_q;
    if (rd_en) begin
      vld_d[rd_q] = 1'b0;
      rd_d = rd_q + PW'(1);
    end
    if (wr0_en) begin
      mem_d[wr_q] = wr0;
      vld_d[wr_q] = 1'b1;
    end
    if (wr1_en) begin
      mem_d[wr1_idx] = wr1;
      vld_d[wr1_idx] = 1'b1;
    end
    wr_d  = wr_q + PW'(wr0_en) + PW'(wr1_en);
    cnt_d = cnt_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign ents   = mem_q;
  assign vld    = vld_q;
  assign rd_ptr = rd_q;
  assign head   = mem_q[rd_q];
  assign count  = cnt_q;
endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: arbitrates ALU/MEM results into an ordered write queue, drains one register file write
// per cycle and forwards pending data onto both read ports
module rf_wb_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    ALU_VALID,
  input  logic [AW-1:0]           ALU_ADDR,
  input  logic [DW-1:0]           ALU_DATA,
  output logic                    ALU_READY,
  input  logic                    MEM_VALID,
  input  logic [AW-1:0]           MEM_ADDR,
  input  logic [DW-1:0]           MEM_DATA,
  output logic                    MEM_READY,
  output logic [AW-1:0]           WADD,
  output logic                    WEN,
  output logic [DW-1:0]           DATAIN,
  input  logic [AW-1:0]           ADD1,
  input  logic [AW-1:0]           ADD2,
  input  logic [DW-1:0]           R1_RF,
  input  logic [DW-1:0]           R2_RF,
  output logic [DW-1:0]           R1,
  output logic [DW-1:0]           R2,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    FULL,
  output logic                    IDLE
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0] vld;
  logic [PW-1:0] rd_ptr;
  wb_entry_t head, wr0, wr1;
  logic [CW-1:0] count, free;
  logic alu_acc, mem_acc, wr0_en, wr1_en, pop;
  logic wen_q, wen_d;
  logic [AW-1:0] wadd_q, wadd_d;
  logic [DW-1:0] datain_q, datain_d;
  rr_t rr_q, rr_d;
  logic [DW-1:0] r1, r2;
  assign free      = CW'(DEPTH) - count;
  assign ALU_READY = (free >= CW'(1)) && !(free == CW'(1) && MEM_VALID && rr_q == RR_MEM);
  assign MEM_READY = (free >= CW'(2)) || (free == CW'(1) && !(ALU_VALID && rr_q == RR_ALU));
  assign alu_acc   = ALU_VALID && ALU_READY;
  assign mem_acc   = MEM_VALID && MEM_READY;
  assign pop       = count != '0;
  // ALU is older on a dual push, so MEM's value wins for a shared destination
  assign wr0_en = alu_acc || mem_acc;
  assign wr0    = alu_acc ? wb_entry_t'{addr: ALU_ADDR, data: ALU_DATA}
                          : wb_entry_t'{addr: MEM_ADDR, data: MEM_DATA};
  assign wr1_en = alu_acc && mem_acc;
  assign wr1    = wb_entry_t'{addr: MEM_ADDR, data: MEM_DATA};
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (CLK),
    .rst_n  (RST_N),
    .wr0_en (wr0_en),
    .wr0    (wr0),
    .wr1_en (wr1_en),
    .wr1    (wr1),
    .rd_en  (pop),
    .ents   (ents),
    .vld    (vld),
    .rd_ptr (rd_ptr),
    .head   (head),
    .count  (count)
  );
  always_comb begin
    wen_d    = pop;
    wadd_d   = pop ? head.addr : wadd_q;
    datain_d = pop ? head.data : datain_q;
    rr_d     = (free == CW'(1) && ALU_VALID && MEM_VALID) ? rr_flip(rr_q) : rr_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wen_q    <= 1'b0;
      wadd_q   <= '0;
      datain_q <= '0;
      rr_q     <= RR_ALU;
    end else begin
      wen_q    <= wen_d;
      wadd_q   <= wadd_d;
      datain_q <= datain_d;
      rr_q     <= rr_d;
    end
  end
  // walk head to tail so the newest matching entry overrides older ones and the output stage
  always_comb begin
    r1 = (wen_q && wadd_q == ADD1) ? datain_q : R1_RF;
    r2 = (wen_q && wadd_q == ADD2) ? datain_q : R2_RF;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[rd_ptr + PW'(i)] && ents[rd_ptr + PW'(i)].addr == ADD1) r1 = ents[rd_ptr + PW'(i)].data;
      if (vld[rd_ptr + PW'(i)] && ents[rd_ptr + PW'(i)].addr == ADD2) r2 = ents[rd_ptr + PW'(i)].data;
    end
  end
  assign R1     = r1;
  assign R2     = r2;
  assign WEN    = wen_q;
  assign WADD   = wadd_q;
  assign DATAIN = datain_q;
  assign COUNT  = count;
  assign FULL   = count == CW'(DEPTH);
  assign IDLE   = (count == '0) && !wen_q;
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: scoreboard bench with a register file model and an architectural reference of register contents
module tb_rf_wb_queue;
  import rf_pkg::*;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic ALU_VALID = 1'b0, MEM_VALID = 1'b0;
  logic [AW-1:0] ALU_ADDR = '0, MEM_ADDR = '0, ADD1 = '0, ADD2 = '0;
  logic [DW-1:0] ALU_DATA = '0, MEM_DATA = '0;
  logic ALU_READY, MEM_READY, WEN, FULL, IDLE;
  logic [AW-1:0] WADD;
  logic [DW-1:0] DATAIN, R1_RF, R2_RF, R1, R2;
  logic [2:0] COUNT;
  logic [DW-1:0] rf_model [NREG];
  logic [DW-1:0] ref_reg [NREG];
  wb_entry_t sb[$];
  logic exp_wen = 1'b0;
  rr_t tb_rr = RR_ALU;
  int n_vec = 0, n_err = 0;

  rf_wb_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .WADD(WADD), .WEN(WEN), .DATAIN(DATAIN),
    .ADD1(ADD1), .ADD2(ADD2), .R1_RF(R1_RF), .R2_RF(R2_RF), .R1(R1), .R2(R2),
    .COUNT(COUNT), .FULL(FULL), .IDLE(IDLE)
  );

  always #5 CLK = ~CLK;
  assign R1_RF = rf_model[ADD1];
  assign R2_RF = rf_model[ADD2];
  always @(posedge CLK) if (WEN) rf_model[WADD] <= DATAIN;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      input logic [AW-1:0] x1, input logic [AW-1:0] x2);
    wb_entry_t e;
    int free;
    logic ar, mr;
    @(negedge CLK);
    check("wen", 32'(WEN), 32'(exp_wen));
    if (exp_wen) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("wadd", 32'(WADD), 32'(e.addr));
        check("datain", 32'(DATAIN), 32'(e.data));
      end
    end
    check("count", 32'(COUNT), 32'(sb.size()));
    check("full", 32'(FULL), 32'(sb.size() == 4));
    check("idle", 32'(IDLE), 32'(sb.size() == 0 && !exp_wen));
    ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
    MEM_VALID = mv; MEM_ADDR = ma; MEM_DATA = md;
    ADD1 = x1; ADD2 = x2;
    #1;
    check("r1_fwd", 32'(R1), 32'(ref_reg[x1]));
    check("r2_fwd", 32'(R2), 32'(ref_reg[x2]));
    free = 4 - sb.size();
    ar = (free >= 1) && !(free == 1 && mv && tb_rr == RR_MEM);
    mr = (free >= 2) || (free == 1 && !(av && tb_rr == RR_ALU));
    check("alu_ready", 32'(ALU_READY), 32'(ar));
    check("mem_ready", 32'(MEM_READY), 32'(mr));
    if (free == 1 && av && mv) tb_rr = (tb_rr == RR_ALU) ? RR_MEM : RR_ALU;
    exp_wen = sb.size() > 0;
    if (av && ar) begin sb.push_back('{addr: aa, data: ad}); ref_reg[aa] = ad; end
    if (mv && mr) begin sb.push_back('{addr: ma, data: md}); ref_reg[ma] = md; end
  endtask

  task automatic idle_step(input logic [AW-1:0] x1, input logic [AW-1:0] x2);
    step(1'b0, '0, '0, 1'b0, '0, '0, x1, x2);
  endtask

  task automatic do_reset();
    ALU_VALID = 1'b0; MEM_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    check("rst_wen", 32'(WEN), 32'd0);
    check("rst_idle", 32'(IDLE), 32'd1);
    check("rst_count", 32'(COUNT), 32'd0);
    sb.delete();
    exp_wen = 1'b0;
    tb_rr = RR_ALU;
    @(negedge CLK);
    @(negedge CLK);
    for (int r = 0; r < NREG; r++) ref_reg[r] = rf_model[r];
    #2 RST_N = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < NREG; r++) check(tag, 32'(rf_model[r]), 32'(ref_reg[r]));
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin rf_model[r] = '0; ref_reg[r] = '0; end
    #2;
    do_reset();
    for (int a = 0; a < NREG; a++) begin
      ADD1 = AW'(a);
      #1 check("rst_r1_passthru", 32'(R1), 32'(R1_RF));
    end
    idle_step(3'd0, 3'd1);
    // single ALU write with forwarding before the register file is updated
    step(1'b1, 3'd3, 16'h1234, 1'b0, '0, '0, 3'd3, 3'd3);
    idle_step(3'd3, 3'd3);
    idle_step(3'd3, 3'd0);
    idle_step(3'd3, 3'd0);
    check("rf3_after_alu", 32'(rf_model[3]), 32'h1234);
    // dual push to the same destination: MEM value is final
    step(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002, 3'd5, 3'd5);
    idle_step(3'd5, 3'd5);
    idle_step(3'd1, 3'd5);
    idle_step(3'd5, 3'd5);
    idle_step(3'd5, 3'd5);
    check("rf5_after_dual", 32'(rf_model[5]), 32'h0002);
    // output stage holds 0xAAAA while 0xBBBB is still queued for the same register
    step(1'b1, 3'd2, 16'hAAAA, 1'b0, '0, '0, 3'd2, 3'd2);
    step(1'b1, 3'd2, 16'hBBBB, 1'b0, '0, '0, 3'd2, 3'd2);
    idle_step(3'd2, 3'd2);
    check("prio_r1", 32'(R1), 32'hBBBB);
    for (int k = 0; k < 4; k++) idle_step(3'd2, 3'd2);
    check("prio_drained", 32'(R1), 32'(R1_RF));
    // sustained back-pressure from both producers
    for (int k = 0; k < 60; k++)
      step(1'b1, AW'($urandom_range(0, 7)), DW'($urandom), 1'b1, AW'($urandom_range(0, 7)), DW'($urandom),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    for (int k = 0; k < 80; k++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 7)), DW'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    for (int k = 0; k < 8; k++) idle_step(AW'(k), AW'(7 - k));
    check_regs("rf_final");
    // reset with three entries queued and one in the output stage
    step(1'b1, 3'd1, 16'hC001, 1'b1, 3'd4, 16'hC002, 3'd1, 3'd4);
    step(1'b1, 3'd6, 16'hC003, 1'b1, 3'd7, 16'hC004, 3'd6, 3'd7);
    idle_step(3'd1, 3'd4);
    check("pre_rst_count", 32'(COUNT), 32'd3);
    check("pre_rst_wen", 32'(WEN), 32'd1);
    do_reset();
    for (int k = 0; k < 6; k++) idle_step(AW'(k), AW'(k + 2));
    check_regs("rf_after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
Write-back initiator for the 8x16 register file, driving the WADD/WEN/DATAIN side of that file.
- Accepts result writes from two producers, ALU and MEM, through valid/ready handshakes, and queues them in order.
- Drains one write per cycle into the register file.
- Forwards pending data onto the two read ports, so readers never see stale operands while writes are queued.

Parameters:
DW, 16, data width (matches register file DATAIN/R1/R2)
AW, 3, register address width (8 registers)
DEPTH, 4, queue entries; power of two, >=2

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
ALU_VALID  in  1  ALU write request
ALU_ADDR  in  AW  ALU destination register
ALU_DATA  in  DW  ALU result
ALU_READY  out  1  ALU request accepted this cycle when VALID&READY
MEM_VALID  in  1  MEM write request
MEM_ADDR  in  AW  MEM destination register
MEM_DATA  in  DW  MEM load data
MEM_READY  out  1  MEM request accepted when VALID&READY
WADD  out  AW  register file write address (registered)
WEN  out  1  register file write enable (registered)
DATAIN  out  DW  register file write data (registered)
ADD1  in  AW  read address 1 (same net as register file ADD1)
ADD2  in  AW  read address 2 (same net as register file ADD2)
R1_RF  in  DW  raw register file R1
R2_RF  in  DW  raw register file R2
R1  out  DW  forwarded operand 1 (combinational)
R2  out  DW  forwarded operand 2 (combinational)
COUNT  out  $clog2(DEPTH)+1  queued entries, excluding the output stage
FULL  out  1  COUNT==DEPTH
IDLE  out  1  COUNT==0 and WEN==0

Behaviour:
Reset (async, RST_N=0):
- Queue empty, COUNT=0.
- WEN=0, WADD=0, DATAIN=0.
- Round-robin flag favours ALU.
- FULL=0, IDLE=1.
- Pending entries are discarded and no further register file write occurs.

Handshake:
- free = DEPTH-COUNT. Pop credit of the same cycle is not counted.
- ALU_READY = free>=1 and not (free==1 and MEM_VALID and rr==MEM).
- MEM_READY = free>=2, or free==1 and not (ALU_VALID and rr==ALU).
- Up to two pushes per cycle. When both are accepted, the ALU entry is enqueued first (older) and the MEM entry second (newer).
- rr toggles only when free==1, both producers are valid, and one is granted; it then points to the loser.

Drain:
- Every rising edge with COUNT>0: pop the head into WADD/DATAIN and set WEN=1. Otherwise WEN=0.
- The register file writes on the next rising edge. The output stage holds its entry for exactly one cycle.
- Latency: push at edge N, pop at edge N+1 if it is at the head, register file updated at edge N+2.
- Push and pop in the same cycle are allowed. COUNT changes by pushes-pops. It never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH.

Ordering:
- Writes reach the register file in acceptance order.
- When ALU and MEM target the same address in one cycle, MEM's value is final.

Forwarding (R1 for ADD1, R2 for ADD2, identical logic). Priority, highest first:
1. Newest matching queue entry, searched tail to head.
2. Output stage, if WEN and WADD match.
3. R1_RF/R2_RF.
Register 0 is an ordinary register with no special case. Forwarding is combinational from current state only; same-cycle incoming requests are not forwarded.

Decomposition:
- Package rf_pkg holds:
  - DW, AW, NREG=8
  - struct wb_entry_t {addr[AW], data[DW]}
  - enum rr_t {RR_ALU, RR_MEM}
- One sub-module, wb_fifo: a DEPTH-entry circular buffer with two writes and one read per cycle. It exposes the entry array and a per-entry valid vector for the top-level forward search.
- Arbitration, the output stage and forwarding live in rf_wb_queue.

Test Plan:
1. Reset -> RST_N=0 mid-cycle: WEN=0, IDLE=1, COUNT=0 immediately. After release, ALU_READY=MEM_READY=1 and R1==R1_RF for all ADD1.
2. ALU write: addr 3, 0x1234 accepted at edge N, ADD1=3, R1_RF=0x0000 -> R1=0x1234 from edge N onward. WEN=1, WADD=3, DATAIN=0x1234 between edges N+1 and N+2. Afterwards IDLE=1 and R1 follows R1_RF.
3. Dual push: ALU addr5/0x0001 and MEM addr5/0x0002 in the same cycle -> ADD2=5 gives R2=0x0002. WEN pulses twice, 0x0001 then 0x0002. COUNT goes 2, then 1, then 0.
4. Back-pressure: both producers valid every cycle with random data, against a register file model -> FULL asserts at COUNT=4. At free==1 the grants alternate ALU, MEM, ALU. Scoreboard shows no loss, duplication or reordering, and the final register contents match the reference model.
5. Forward priority: addr 2 with 0xAAAA in the output stage and 0xBBBB queued, ADD1=2 -> R1=0xBBBB. After both drain, R1=R1_RF.
6. Reset mid-operation: COUNT=3 with WEN=1, then RST_N=0 -> WEN=0 at once. No writes follow after release. The register file model holds only writes completed before reset.
